// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants, state encoding and parity helper for the FIFO-fed UART transmitter.
package uart_tx_fifo_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_720P = 645;
    localparam int unsigned UART_CLKS_PER_BIT_480P = 234;

    localparam int unsigned UART_PARITY_NONE = 0;
    localparam int unsigned UART_PARITY_EVEN = 1;
    localparam int unsigned UART_PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Parity bit that makes the total count of ones even (EVEN) or odd (ODD).
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == UART_PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8 data bits, LSB first, optional parity, 1/2 stop bits) fed by a byte FIFO.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_720P,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY       = UART_PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t   r_state;
    uart_tx_state_t   w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_data;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;
    logic [LVL_W-1:0] w_level;
    logic             w_baud_done;
    logic             w_last_bit;
    logic             w_stop_done;

    assign w_push = tx_valid && !w_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (tx_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign w_baud_done = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    // In STOP the bit counter counts stop bits, so two stop bits need no wider baud counter.
    assign w_stop_done = w_baud_done && (r_bit_cnt == 3'(STOP_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (!w_empty)   w_state_nxt = START;
            START: if (w_baud_done) w_state_nxt = DATA;
            DATA:  if (w_baud_done && w_last_bit)
                       w_state_nxt = (PARITY != UART_PARITY_NONE) ? uart_tx_fifo_pkg::PARITY : STOP;
            uart_tx_fifo_pkg::PARITY: if (w_baud_done) w_state_nxt = STOP;
            STOP:  if (w_stop_done) w_state_nxt = w_empty ? IDLE : START;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pop on leaving IDLE or on the last stop cycle, so back-to-back frames have no gap.
    always_comb begin
        w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_stop_done));
        w_bit_nxt = r_bit_cnt;
        if (w_state_nxt != r_state) w_bit_nxt = 3'd0;
        else if (w_baud_done)       w_bit_nxt = r_bit_cnt + 3'd1;
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            START:                    w_txd_nxt = 1'b0;
            DATA:                     w_txd_nxt = r_data[w_bit_nxt];
            uart_tx_fifo_pkg::PARITY: w_txd_nxt = parity_bit(r_data, PARITY);
            default:                  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_txd      <= 1'b1;
        end else begin
            if ((r_state == IDLE) || (w_state_nxt != r_state) || w_baud_done)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            r_bit_cnt <= w_bit_nxt;
            if (w_pop) r_data <= w_head;
            r_txd <= w_txd_nxt;
        end
    end

    assign txd        = r_txd;
    assign tx_ready   = !w_full;
    assign busy       = (r_state != IDLE) || (w_level != '0);
    assign fifo_level = w_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five parameterisations checked every cycle against a waveform-queue model.
module tb_uart_tx_fifo;

    localparam int NI = 5;
    localparam int CPB_T [NI] = '{4, 4, 4, 4, 645};
    localparam int PAR_T [NI] = '{0, 1, 2, 0, 0};
    localparam int STP_T [NI] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_v      [NI];
    logic       tx_valid_v [NI];
    logic [7:0] tx_data_v  [NI];
    logic       tx_ready_v [NI];
    logic       txd_v      [NI];
    logic       busy_v     [NI];
    logic [4:0] lvl_v      [NI];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #6734ps clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .rst(rst_v[0]), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(tx_ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .fifo_level(lvl_v[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst_v[1]), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(tx_ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .fifo_level(lvl_v[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst_v[2]), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
        .tx_ready(tx_ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .fifo_level(lvl_v[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst_v[3]), .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]),
        .tx_ready(tx_ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .fifo_level(lvl_v[3]));
    uart_tx_fifo #(.CLKS_PER_BIT(645), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_720p (
        .clk(clk), .rst(rst_v[4]), .tx_data(tx_data_v[4]), .tx_valid(tx_valid_v[4]),
        .tx_ready(tx_ready_v[4]), .txd(txd_v[4]), .busy(busy_v[4]), .fifo_level(lvl_v[4]));

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Model: queued bytes plus the remaining txd samples of the frame on the wire.
    logic [7:0] mq [NI][$];
    bit         mw [NI][$];
    bit         mtxd [NI];
    bit         mact [NI];

    always @(posedge clk) begin
        bit         acc;
        bit         p;
        logic [7:0] b;
        for (int i = 0; i < NI; i++) begin
            if (rst_v[i]) begin
                mq[i].delete();
                mw[i].delete();
                mtxd[i] = 1'b1;
                mact[i] = 1'b0;
            end else begin
                acc = tx_valid_v[i] && (mq[i].size() < 16);
                if (mw[i].size() == 0 && mq[i].size() != 0) begin
                    b = mq[i].pop_front();
                    for (int k = 0; k < CPB_T[i]; k++) mw[i].push_back(1'b0);
                    for (int j = 0; j < 8; j++)
                        for (int k = 0; k < CPB_T[i]; k++) mw[i].push_back(b[j]);
                    if (PAR_T[i] != 0) begin
                        p = ($countones(b) % 2) == 1;
                        if (PAR_T[i] == 2) p = !p;
                        for (int k = 0; k < CPB_T[i]; k++) mw[i].push_back(p);
                    end
                    for (int k = 0; k < STP_T[i] * CPB_T[i]; k++) mw[i].push_back(1'b1);
                end
                if (mw[i].size() != 0) begin
                    mtxd[i] = mw[i].pop_front();
                    mact[i] = 1'b1;
                end else begin
                    mtxd[i] = 1'b1;
                    mact[i] = 1'b0;
                end
                if (acc) mq[i].push_back(tx_data_v[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("txd", i, txd_v[i], mtxd[i]);
                chk("tx_ready", i, tx_ready_v[i], (mq[i].size() != 16));
                chk("busy", i, busy_v[i], (mact[i] || mq[i].size() != 0));
                chk("fifo_level", i, lvl_v[i], mq[i].size());
            end
        end
    end

    task automatic push(input int i, input logic [7:0] b);
        tx_valid_v[i] = 1'b1;
        tx_data_v[i]  = b;
        @(negedge clk);
        tx_valid_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int lim);
        int n;
        n = 0;
        while (busy_v[i] !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", i, busy_v[i], 0);
    endtask

    // Bench receiver: samples mid-bit, returns the byte and whether the stop bit was high.
    task automatic rx_decode(input int i, input int cpb, output logic [7:0] b, output logic ok);
        int n;
        n  = 0;
        b  = '0;
        ok = 1'b0;
        while (txd_v[i] !== 1'b0 && n < 12 * cpb + 50) begin
            @(negedge clk);
            n++;
        end
        if (txd_v[i] !== 1'b0) begin
            chk("rx_start", i, txd_v[i], 0);
            return;
        end
        repeat (cpb / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            repeat (cpb) @(negedge clk);
            b[j] = txd_v[i];
        end
        repeat (cpb) @(negedge clk);
        ok = (txd_v[i] === 1'b1);
    endtask

    // pat[j] is the hand-written txd level of bit period j (start first); CLKS_PER_BIT=4.
    task automatic run_frame(input int i, input logic [7:0] b, input logic [15:0] pat,
                             input int nbits, input string name);
        logic [63:0] cap;
        logic [63:0] expv;
        cap  = '0;
        expv = '0;
        push(i, b);
        chk({name, "_acc_txd"}, i, txd_v[i], 1);
        chk({name, "_acc_lvl"}, i, lvl_v[i], 1);
        @(negedge clk);
        for (int k = 0; k < nbits * 4; k++) begin
            cap[k]  = txd_v[i];
            expv[k] = pat[k / 4];
            @(negedge clk);
        end
        chk(name, i, cap, expv);
        chk({name, "_end_txd"}, i, txd_v[i], 1);
        chk({name, "_end_busy"}, i, busy_v[i], 0);
    endtask

    initial begin
        logic [7:0]  rb;
        logic        rok;
        logic [63:0] cap;
        int          d;
        int          guard;
        logic        acc;
        int          lows;
        int          highs;

        for (int i = 0; i < NI; i++) begin
            rst_v[i]      = 1'b1;
            tx_valid_v[i] = 1'b0;
            tx_data_v[i]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("rst_txd", 0, txd_v[0], 1);
        chk("rst_ready", 0, tx_ready_v[0], 1);
        chk("rst_busy", 0, busy_v[0], 0);
        chk("rst_lvl", 0, lvl_v[0], 0);
        chk_en = 1'b1;
        for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
        @(negedge clk);

        // 0x55, no parity: 0,1,0,1,0,1,0,1,0,1
        run_frame(0, 8'h55, 16'b0000_0010_1010_1010, 10, "frame55");
        // 0xA5 even parity -> parity 0; odd parity -> parity 1
        run_frame(1, 8'hA5, 16'b0000_0101_0100_1010, 11, "frameA5_even");
        run_frame(2, 8'hA5, 16'b0000_0111_0100_1010, 11, "frameA5_odd");

        // 17 bytes with tx_valid held; receiver runs alongside
        fork
            begin
                d     = 0;
                guard = 0;
                while (d < 17 && guard < 200) begin
                    tx_valid_v[0] = 1'b1;
                    tx_data_v[0]  = 8'(d);
                    acc = tx_ready_v[0];
                    @(negedge clk);
                    if (acc) d++;
                    guard++;
                end
                tx_valid_v[0] = 1'b0;
                chk("burst_pushed", 0, d, 17);
                chk("burst_lvl", 0, lvl_v[0], 16);
                chk("burst_ready", 0, tx_ready_v[0], 0);
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    rx_decode(0, 4, rb, rok);
                    chk("burst_byte", k, rb, k);
                    chk("burst_stop", k, rok, 1);
                end
            end
        join
        wait_idle(0, 200);

        // Two stop bits: next start at cycle 44 of the first frame
        tx_valid_v[3] = 1'b1;
        tx_data_v[3]  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        tx_valid_v[3] = 1'b0;
        cap = '0;
        for (int k = 0; k < 48; k++) begin
            cap[k] = txd_v[3];
            @(negedge clk);
        end
        chk("stop2_wave", 3, cap[47:0], 48'h0FFF_FFFF_FFF0);
        wait_idle(3, 200);

        // Reset in the middle of byte 0's data bits with two more queued
        tx_valid_v[0] = 1'b1;
        tx_data_v[0]  = 8'h11;
        @(negedge clk);
        tx_data_v[0]  = 8'h22;
        @(negedge clk);
        tx_data_v[0]  = 8'h33;
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("rstmid_txd", 0, txd_v[0], 1);
        chk("rstmid_lvl", 0, lvl_v[0], 0);
        chk("rstmid_ready", 0, tx_ready_v[0], 1);
        chk("rstmid_busy", 0, busy_v[0], 0);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            if (txd_v[0] !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("rstmid_quiet", 0, lows, 0);
        push(0, 8'hC3);
        rx_decode(0, 4, rb, rok);
        chk("rstmid_after", 0, rb, 8'hC3);
        chk("rstmid_after_stop", 0, rok, 1);
        wait_idle(0, 100);

        // 720p baud: 0x3C -> start+bit0+bit1 low (3 periods), bits 2..5 high (4 periods)
        push(4, 8'h3C);
        fork
            begin
                rx_decode(4, 645, rb, rok);
                chk("baud720_byte", 4, rb, 8'h3C);
                chk("baud720_stop", 4, rok, 1);
            end
            begin
                guard = 0;
                while (txd_v[4] !== 1'b0 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                lows = 0;
                while (txd_v[4] === 1'b0 && lows < 5000) begin
                    lows++;
                    @(negedge clk);
                end
                highs = 0;
                while (txd_v[4] === 1'b1 && highs < 5000) begin
                    highs++;
                    @(negedge clk);
                end
                chk("baud720_low_run", 4, lows, 1935);
                chk("baud720_high_run", 4, highs, 2580);
            end
        join
        wait_idle(4, 8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
